// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one add-and-shift per clock, start/ready handshake.
// Optional MUL_ZERO_SKIP_EN: a zero operand skips RUN and finishes in one cycle.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // RUN   | one add-and-shift per cycle, busy=1
    // DONE  | result in product, done=1 for one cycle

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mc;
    logic [2*WIDTH-1:0]   p;
    logic [2*WIDTH-1:0]   p_shift;
    logic [2*WIDTH-1:0]   product_q;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic                 last_step;
    logic                 zero_op;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // The adder carry lands in the top bit of the shifted P, so nothing is lost.
    always_comb begin
        addend    = p[0] ? mc : '0;
        sum       = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        p_shift   = {sum, p[WIDTH-1:1]};
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc        <= '0;
            p         <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mc  <= a;
                        cnt <= '0;
                        if (zero_op) begin
                            p         <= '0;
                            product_q <= '0;
                        end else begin
                            p <= {{WIDTH{1'b0}}, b};
                        end
                    end
                end
                RUN: begin
                    p   <= p_shift;
                    cnt <= cnt + CNT_W'(1);
                    // product changes only when the final step lands
                    if (last_step) begin
                        product_q <= p_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=4): reset, basic, carry, ignored start,
// mid-run reset, zero operand and all 256 operand pairs back to back.
module tb_shift_add_multiplier;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_vec = 0;
    int n_err = 0;
    bit chk_excl = 0;

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUL_ZERO_SKIP_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 5;
    localparam int ZERO_BUSY = 4;
`endif

    always @(negedge clk) begin
        if (chk_excl && !rst) begin
            n_vec++;
            if ((int'(ready) + int'(busy) + int'(done)) != 1) begin
                n_err++;
                $display("FAIL exclusive: ready=%0b busy=%0b done=%0b required exactly one", ready, busy, done);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] av, input logic [3:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called one tick after the start edge (cycle 1). Returns the cycle in which
    // done is seen (0 on timeout) and how many busy cycles preceded it.
    task automatic wait_done(output int cyc, output int busy_cyc);
        busy_cyc = 0;
        cyc      = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            if (busy) busy_cyc++;
            step();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd5;
        step();
        step();
        n_vec++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/busy/done=%b required 100", {ready, busy, done});
        end
        n_vec++;
        if (product !== 8'd0) begin
            n_err++;
            $display("FAIL reset_product: got %0d required 0", product);
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        n_vec++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_no_start: got rdy/busy/done=%b required 100", {ready, busy, done});
        end
        chk_excl = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, bc;
        start_op(4'd3, 4'd5);
        wait_done(cyc, bc);
        n_vec++;
        if (cyc != 5) begin
            n_err++;
            $display("FAIL basic_latency: got cycle %0d required 5", cyc);
        end
        n_vec++;
        if (bc != 4) begin
            n_err++;
            $display("FAIL basic_busy: got %0d busy cycles required 4", bc);
        end
        n_vec++;
        if (product !== 8'd15) begin
            n_err++;
            $display("FAIL basic_product: got %0d required 15", product);
        end
        step();
        n_vec++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_strobe: got done=%0b ready=%0b required 0 1", done, ready);
        end
        step();
        step();
        n_vec++;
        if (product !== 8'd15) begin
            n_err++;
            $display("FAIL basic_hold: got %0d required 15", product);
        end
    endtask

    task automatic test_max();
        int cyc, bc;
        start_op(4'd15, 4'd15);
        wait_done(cyc, bc);
        n_vec++;
        if (cyc != 5 || product !== 8'd225) begin
            n_err++;
            $display("FAIL max_product: got %0d at cycle %0d required 225 at 5", product, cyc);
        end
        step();
    endtask

    task automatic test_ignored_start();
        int dones;
        logic [7:0] res;
        dones = 0;
        res   = 8'hxx;
        start_op(4'd7, 4'd9);
        n_vec++;
        if (product !== 8'd225) begin
            n_err++;
            $display("FAIL run_holds_prev: got %0d required 225", product);
        end
        a     = 4'd2;
        b     = 4'd2;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                res = product;
            end
            step();
        end
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL ignored_done_count: got %0d required 1", dones);
        end
        n_vec++;
        if (res !== 8'd63) begin
            n_err++;
            $display("FAIL ignored_product: got %0d required 63", res);
        end
    endtask

    task automatic test_zero();
        int cyc, bc;
        start_op(4'd0, 4'd9);
        wait_done(cyc, bc);
        n_vec++;
        if (cyc != ZERO_LAT) begin
            n_err++;
            $display("FAIL zero_latency: got cycle %0d required %0d", cyc, ZERO_LAT);
        end
        n_vec++;
        if (bc != ZERO_BUSY) begin
            n_err++;
            $display("FAIL zero_busy: got %0d busy cycles required %0d", bc, ZERO_BUSY);
        end
        n_vec++;
        if (product !== 8'd0) begin
            n_err++;
            $display("FAIL zero_product: got %0d required 0", product);
        end
        step();
    endtask

    task automatic test_mid_reset();
        int dones;
        // seed a nonzero result so the reset clear is visible
        start_op(4'd3, 4'd5);
        for (int i = 0; i < 6; i++) step();
        start_op(4'd7, 4'd9);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_flags: got rdy/busy/done=%b required 100", {ready, busy, done});
        end
        n_vec++;
        if (product !== 8'd0) begin
            n_err++;
            $display("FAIL abort_product: got %0d required 0", product);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            step();
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d dones required 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc, lat;
        logic [3:0] ai, bi;
        logic [7:0] expv;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ai   = 4'(i >> 4);
            bi   = 4'(i & 15);
            expv = {4'b0, ai} * {4'b0, bi};
            lat  = 5;
`ifdef MUL_ZERO_SKIP_EN
            if (ai == 4'd0 || bi == 4'd0) lat = 1;
`endif
            n_vec++;
            if (ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %0b required 1", i, ready);
            end
            a = ai;
            b = bi;
            step();
            a = ~ai;
            b = ~bi;
            wait_done(cyc, bc);
            n_vec++;
            if (cyc != lat || product !== expv) begin
                n_err++;
                $display("FAIL b2b_%0dx%0d: got %0d at cycle %0d required %0d at %0d",
                         ai, bi, product, cyc, expv, lat);
            end
            step();
        end
        start = 1'b0;
        step();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_basic();
        test_max();
        test_ignored_start();
        test_zero();
        test_mid_reset();
        test_back_to_back();
        chk_excl = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned shift-and-add multiplier built around the 4-bit ripple adder datapath. It accepts two operands through a start/ready handshake and iterates one add-and-shift per clock. It consumes the adder's (WIDTH+1)-bit sum/carry each step and produces a 2*WIDTH-bit product with a one-cycle done strobe. It sits directly downstream of the Adder stage in the ALU path.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; the step counter is sized to hold WIDTH.

Ports:
clk      input   1          single clock, all state updates on rising edge
rst      input   1          synchronous, active-high reset
start    input   1          request; sampled only while ready=1
a        input   WIDTH      multiplicand, captured on accepted start
b        input   WIDTH      multiplier, captured on accepted start
ready    output  1          1 in IDLE only
busy     output  1          1 in RUN only
done     output  1          one-cycle strobe in DONE
product  output  2*WIDTH    result; valid from done, held until next accepted start

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. This is fixed.
- Reset (rst=1 at a rising edge) has priority over every other input:
  - state -> IDLE
  - product=0, done=0, busy=0, ready=1
  - internal registers cleared: multiplicand, P register, carry, step counter
- rst=1 during RUN aborts the operation. No done is produced. product reads 0 after the edge.
- Datapath registers:
  - MC (WIDTH bits) holds the multiplicand.
  - P (2*WIDTH bits): upper half is the accumulator, lower half is the multiplier.
  - cnt counts steps.
- States and transitions:
  - IDLE: ready=1. On start=1: MC<=a, P<={0,b}, cnt<=0, go to RUN.
  - RUN: busy=1. Each cycle, sum[WIDTH:0] = P[2W-1:W] + (P[0] ? MC : 0). The sum is full (WIDTH+1) bits and the carry is never dropped.
    - Then P <= {sum, P[W-1:1]} (right shift of carry:upper:lower by one).
    - cnt<=cnt+1.
    - When cnt reaches WIDTH-1 on this edge, go to DONE.
  - DONE: done=1 for exactly one cycle. product holds P. Next state is IDLE unconditionally.
- product is driven from the register P and updates only as follows:
  - Loaded with the final P on entry to DONE.
  - Held through DONE and IDLE until the next accepted start.
  - During RUN, product keeps the previous result.
- Latency: start sampled at edge E0 -> RUN on edges E1..EW -> done high in the cycle after edge EW. That is WIDTH+1 cycles from the start edge to done (5 for WIDTH=4).
- start while busy or done is ignored, with no queuing. Operands a and b may change freely after acceptance.
- start held high continuously: a new operation is accepted on each return to IDLE. Throughput is one result per WIDTH+2 cycles.
- Boundaries:
  - 0*x = 0.
  - Max (2^W-1)^2, e.g. 225 for W=4, fits exactly in 2*WIDTH bits.
  - cnt wraps only through the DONE->IDLE reload, never mid-run.
- busy, ready and done are mutually exclusive; exactly one is 1 at any time after reset.

Optional Feature:
Macro: MUL_ZERO_SKIP_EN
- Defined: on an accepted start with a==0 or b==0:
  - go directly IDLE -> DONE, with P<=0 and product<=0.
  - done is asserted the cycle after the start edge (latency 1).
  - RUN is not entered and busy stays 0.
- Not defined: zero operands take the full WIDTH+1 latency like any other pair, and the product is 0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> ready=1, busy=0, done=0, product=0; no operation starts.
- Basic: a=3, b=5, start pulse -> busy for 4 cycles; done=1 exactly 5 cycles after the start edge; product=15 (8'b00001111), held until next start.
- Max/carry: a=15, b=15 -> product=225 (8'b11100001), checking carry propagation from the adder sum into P.
- Ignored start and mid-run reset:
  - a=7, b=9 accepted; start re-pulsed with a=2, b=2 during RUN -> product=63, and only one done.
  - Repeat with rst=1 on the 2nd RUN cycle -> back in IDLE next cycle, no done, product=0.
- Zero operand: a=0, b=9.
  - With MUL_ZERO_SKIP_EN: done the cycle after start, busy never 1, product=0.
  - Without it: done at 5 cycles, product=0.
- Exhaustive: all 256 (a,b) pairs, a,b in 0..15, with start back-to-back -> each done's product equals a*b, checked against a behavioural model.
